// File: rtl/regfile_sb.sv
// Multi-port integer register file with per-register pending scoreboard,
// same-cycle writeback forwarding and a zeroing sequencer for reset and clr_req.
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int AW     = 5,
    parameter int RPORTS = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [RPORTS-1:0]        rd_en,
    input  logic [RPORTS*AW-1:0]     rd_addr,
    output logic [RPORTS*XLEN-1:0]   rd_data,
    output logic [RPORTS-1:0]        rd_pending,
    input  logic                     wb_en,
    input  logic [AW-1:0]            wb_addr,
    input  logic [XLEN-1:0]          wb_data,
    input  logic                     iss_en,
    input  logic [AW-1:0]            iss_addr,
    input  logic                     flush,
    input  logic                     clr_req,
    output logic                     busy
);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_e;

    localparam logic [AW:0]   NREG_W = (AW+1)'(NREG);
    localparam logic [AW-1:0] LAST   = AW'(NREG - 1);

    state_e            state_q;
    logic [AW-1:0]     ptr_q;
    logic              busy_q;
    logic [NREG-1:0]   pend_q;
    logic [NREG-1:0]   pend_d;
    logic [XLEN-1:0]   regs_q [NREG];
    logic [AW-1:0]     ra;
    logic              fwd;
    logic              wb_ok;

    // Nonzero and below NREG: the only addresses backed by real storage.
    function automatic logic valid_addr(input logic [AW-1:0] a);
        return (a != '0) && ({1'b0, a} < NREG_W);
    endfunction

    assign busy  = busy_q;
    assign wb_ok = wb_en && valid_addr(wb_addr);

    // Set after clear so a same-address issue wins over its older producer's writeback.
    always_comb begin
        pend_d = pend_q;
        if (flush) begin
            pend_d = '0;
        end else begin
            if (wb_ok) begin
                pend_d[wb_addr] = 1'b0;
            end
            if (iss_en && valid_addr(iss_addr)) begin
                pend_d[iss_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CLEAR;
            ptr_q   <= AW'(1);
            busy_q  <= 1'b1;
            pend_q  <= '0;
        end else begin
            case (state_q)
                CLEAR: begin
                    ptr_q <= ptr_q + AW'(1);
                    if (ptr_q == LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (clr_req) begin
                        state_q <= CLEAR;
                        ptr_q   <= AW'(1);
                        busy_q  <= 1'b1;
                        pend_q  <= '0;
                    end else begin
                        pend_q <= pend_d;
                    end
                end
                default: begin
                    state_q <= CLEAR;
                    ptr_q   <= AW'(1);
                    busy_q  <= 1'b1;
                    pend_q  <= '0;
                end
            endcase
        end
    end

    // Storage has no reset; the sequencer zeroes it one register per cycle.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            regs_q[ptr_q] <= '0;
        end else if (wb_ok) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    always_comb begin
        rd_data    = '0;
        rd_pending = '0;
        ra         = '0;
        fwd        = 1'b0;
        for (int unsigned i = 0; i < RPORTS; i++) begin
            ra  = rd_addr[i*AW +: AW];
            fwd = wb_en && (wb_addr == ra);
            if (!busy_q && rd_en[i] && valid_addr(ra)) begin
                rd_data[i*XLEN +: XLEN] = fwd ? wb_data : regs_q[ra];
                rd_pending[i]           = pend_q[ra] && !fwd;
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized bench for regfile_sb against an array/counter reference model.
module tb_regfile_sb;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int AW     = 5;
    localparam int RPORTS = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [RPORTS-1:0]      rd_en;
    logic [RPORTS*AW-1:0]   rd_addr;
    logic [RPORTS*XLEN-1:0] rd_data;
    logic [RPORTS-1:0]      rd_pending;
    logic                   wb_en;
    logic [AW-1:0]          wb_addr;
    logic [XLEN-1:0]        wb_data;
    logic                   iss_en;
    logic [AW-1:0]          iss_addr;
    logic                   flush;
    logic                   clr_req;
    logic                   busy;

    regfile_sb #(
        .XLEN  (XLEN),
        .NREG  (NREG),
        .AW    (AW),
        .RPORTS(RPORTS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_pending(rd_pending),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .flush     (flush),
        .clr_req   (clr_req),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [XLEN-1:0] mreg  [NREG];
    bit              mpend [NREG];
    int              busy_left = NREG - 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic clear_model();
        for (int r = 0; r < NREG; r++) begin
            mreg[r]  = '0;
            mpend[r] = 1'b0;
        end
    endtask

    task automatic check_outputs();
        bit              mbusy;
        logic [AW-1:0]   a;
        logic [XLEN-1:0] ed;
        bit              ep;
        mbusy = !rst || (busy_left > 0);
        check("busy", {31'd0, busy}, {31'd0, mbusy});
        for (int p = 0; p < RPORTS; p++) begin
            a  = rd_addr[p*AW +: AW];
            ed = '0;
            ep = 1'b0;
            if (!mbusy && rd_en[p] && a != 0) begin
                if (wb_en && wb_addr == a) begin
                    ed = wb_data;
                end else begin
                    ed = mreg[a];
                    ep = mpend[a];
                end
            end
            check($sformatf("rd_data[%0d]", p), rd_data[p*XLEN +: XLEN], ed);
            check($sformatf("rd_pending[%0d]", p), {31'd0, rd_pending[p]}, {31'd0, ep});
        end
    endtask

    task automatic model_edge();
        if (!rst) begin
            busy_left = NREG - 1;
            clear_model();
        end else if (busy_left > 0) begin
            busy_left--;
        end else if (clr_req) begin
            busy_left = NREG - 1;
            clear_model();
        end else begin
            if (wb_en && wb_addr != 0) mreg[wb_addr] = wb_data;
            if (flush) begin
                for (int r = 0; r < NREG; r++) mpend[r] = 1'b0;
            end else begin
                if (wb_en) mpend[wb_addr] = 1'b0;
                if (iss_en && iss_addr != 0) mpend[iss_addr] = 1'b1;
            end
        end
    endtask

    // Check combinational outputs mid-cycle, advance model on the edge, then settle.
    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_in();
        rd_en = '0; rd_addr = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        iss_en = 1'b0; iss_addr = '0;
        flush = 1'b0; clr_req = 1'b0;
    endtask

    task automatic count_busy(input string tag);
        int n;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check(tag, n, NREG - 1);
    endtask

    task automatic read2(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_en   = 2'b11;
        rd_addr = {a1, a0};
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout n_chk=%0d", n_chk);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        idle_in();
        clear_model();
        repeat (3) tick();

        // Release reset; a writeback during zeroing must be dropped.
        @(posedge clk); #1;
        rst = 1'b1;
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hCAFE_F00D;
        count_busy("busy_after_reset");
        idle_in();
        rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
        #1 check("x5_dropped", rd_data[31:0], 32'h0);
        tick();
        for (int r = 0; r < NREG; r += 2) begin
            read2(AW'(r), AW'(r + 1));
            tick();
        end

        idle_in();
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEAD_BEEF;
        tick();
        idle_in();
        read2(5'd3, 5'd0);
        #1 check("x3_read", rd_data[31:0], 32'hDEAD_BEEF);
        check("x0_read", rd_data[63:32], 32'h0);
        tick();
        idle_in();
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234;
        tick();
        idle_in();
        read2(5'd0, 5'd0);
        #1 check("x0_after_write", rd_data[31:0], 32'h0);
        tick();

        // Forwarding must follow the address, not leak onto other ports.
        idle_in();
        wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'h1111_2222;
        tick();
        wb_addr = 5'd7; wb_data = 32'hA5A5_A5A5;
        read2(5'd7, 5'd8);
        #1 check("fwd_x7", rd_data[31:0], 32'hA5A5_A5A5);
        check("no_fwd_x8", rd_data[63:32], 32'h1111_2222);
        tick();

        idle_in();
        iss_en = 1'b1; iss_addr = 5'd9;
        tick();
        idle_in();
        read2(5'd9, 5'd9);
        #1 check("x9_pending", {31'd0, rd_pending[0]}, 32'd1);
        tick();
        #1 check("x9_still_pending", {31'd0, rd_pending[1]}, 32'd1);
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h0000_0099;
        #1 check("x9_wb_not_pending", {31'd0, rd_pending[0]}, 32'd0);
        check("x9_wb_fwd", rd_data[31:0], 32'h99);
        tick();
        idle_in();
        iss_en = 1'b1; iss_addr = 5'd9;
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h0000_0777;
        tick();
        idle_in();
        read2(5'd9, 5'd9);
        #1 check("x9_set_wins", {31'd0, rd_pending[0]}, 32'd1);
        tick();
        idle_in();
        flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd4;
        tick();
        idle_in();
        read2(5'd4, 5'd9);
        #1 check("flush_x4", {31'd0, rd_pending[0]}, 32'd0);
        check("flush_x9", {31'd0, rd_pending[1]}, 32'd0);
        tick();

        // Fill everything, leave some pending, then re-zero.
        for (int r = 1; r < NREG; r++) begin
            idle_in();
            wb_en = 1'b1; wb_addr = AW'(r); wb_data = (32'h0101_0101 * r) | 32'h1;
            iss_en = 1'b1; iss_addr = AW'(NREG - r);
            tick();
        end
        idle_in();
        clr_req = 1'b1;
        tick();
        idle_in();
        clr_req = 1'b1;
        count_busy("busy_after_clr");
        idle_in();
        for (int r = 1; r < NREG; r++) begin
            read2(AW'(r), AW'(r));
            #1 check("clr_zero", rd_data[31:0], 32'h0);
            check("clr_no_pend", {31'd0, rd_pending[1]}, 32'd0);
            tick();
        end

        // Reset in the middle of zeroing restarts the full sequence.
        idle_in();
        clr_req = 1'b1;
        tick();
        idle_in();
        repeat (10) tick();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        count_busy("busy_after_mid_rst");

        for (int c = 0; c < 3000; c++) begin
            rd_en    = RPORTS'($urandom);
            rd_addr  = (RPORTS*AW)'($urandom);
            wb_en    = 1'($urandom);
            wb_addr  = ($urandom_range(3) == 0) ? rd_addr[AW-1:0] : AW'($urandom);
            wb_data  = $urandom;
            iss_en   = 1'($urandom);
            iss_addr = ($urandom_range(7) == 0) ? wb_addr : AW'($urandom);
            flush    = ($urandom_range(15) == 0);
            clr_req  = ($urandom_range(199) == 0);
            rst      = ($urandom_range(799) != 0);
            tick();
        end
        rst = 1'b1;
        idle_in();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised multi-read-port integer register file with a built-in scoreboard and a hardware zeroing sequencer.
- Sits between decode/issue and writeback in the rv32i pipeline.
- Supplies RPORTS operands per cycle with same-cycle writeback forwarding.
- Tracks which registers have an in-flight producer, so the hazard unit can stall without its own tracking logic.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers; register 0 is hardwired zero.
- AW, 5, address width; must satisfy 2**AW >= NREG.
- RPORTS, 2, number of independent read ports (1..4).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- rd_en  in  RPORTS  per-port read enable.
- rd_addr  in  RPORTS*AW  packed read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  RPORTS*XLEN  packed read data; port i occupies bits [i*XLEN +: XLEN].
- rd_pending  out  RPORTS  1 = the addressed register still awaits a producer's writeback.
- wb_en  in  1  writeback enable.
- wb_addr  in  AW  writeback address.
- wb_data  in  XLEN  writeback data.
- iss_en  in  1  an instruction issued; mark its destination pending.
- iss_addr  in  AW  destination of the issued instruction.
- flush  in  1  clear all pending bits (pipeline squash).
- clr_req  in  1  request a full re-zeroing of all registers.
- busy  out  1  zeroing sequencer active; the block accepts no writes or issues.

Behaviour:
- FSM states: CLEAR, IDLE.
  - rst low: state=CLEAR, ptr=1, all pending bits=0, busy=1.
  - Register contents are not reset directly; the sequencer clears them.
- CLEAR:
  - Each cycle writes 0 to reg[ptr] and increments ptr.
  - When ptr==NREG-1, that final write occurs and state goes to IDLE.
  - busy=1 for exactly NREG-1 cycles after rst deasserts, i.e. 31 cycles at default.
- IDLE:
  - busy=0.
  - clr_req=1 sets ptr=1, state=CLEAR, and clears all pending bits on the next edge.
  - clr_req is ignored while already in CLEAR (no restart).
- While busy:
  - wb_en, iss_en and flush are ignored.
  - rd_data=0 and rd_pending=0 on all ports.
- Write (IDLE only):
  - wb_en && wb_addr!=0 && wb_addr<NREG: reg[wb_addr] <= wb_data on the rising edge.
  - Writes to address 0 or out of range are dropped.
- Read (combinational, per port i), priority order:
  1. rd_en[i]=0 gives 0.
  2. rd_addr==0 or rd_addr>=NREG gives 0.
  3. wb_en && wb_addr==rd_addr gives wb_data (forwarding; the address must match).
  4. Otherwise reg[rd_addr].
- rd_pending[i] = rd_en[i] && addr!=0 && pending[addr] && !(wb_en && wb_addr==addr). A value being forwarded this cycle is not pending.
- Pending update on each edge (IDLE only), priority order:
  1. flush clears every bit; a same-cycle iss is also discarded.
  2. iss_en && iss_addr!=0 sets pending[iss_addr].
  3. wb_en clears pending[wb_addr].
  - Same address iss+wb in one cycle: set wins (newer producer).
  - pending[0] is constantly 0.
- All read ports are fully independent; any number may address the same register in the same cycle.
- rst asserted mid-CLEAR or mid-operation: immediate return to CLEAR with ptr=1. The sequence restarts in full.

Test Plan:
- Reset release -> busy=1 for 31 cycles, then 0; every register reads 0; a wb_en to x5 during busy is dropped (x5 reads 0 afterwards).
- IDLE: write x3=0xDEADBEEF; next cycle read port0=x3, port1=x0 -> 0xDEADBEEF, 0x00000000; a write to x0 of 0x1234 -> x0 still reads 0.
- Same-cycle wb x7=0xA5A5A5A5 with port0 reading x7 and port1 reading x8 -> port0 returns 0xA5A5A5A5 combinationally; port1 returns the old x8, not wb_data.
- Scoreboard:
  - iss x9 -> rd_pending=1 on the following cycles.
  - wb x9 cycle -> rd_pending=0 and data forwarded.
  - iss x9 and wb x9 in the same cycle -> x9 remains pending.
  - flush with iss x4 -> nothing pending.
- clr_req in IDLE after writing x1..x31 nonzero -> busy=1 for 31 cycles, all registers read 0, all pending bits 0.
- rst pulsed low at cycle 10 of CLEAR -> busy remains high for a full 31 cycles after release.
